// File: rtl/ea_gen_unit.sv
// ea_gen_unit: sequenced effective-address generator with operand fetch and page-cross flag
module ea_gen_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int NUM_IDX = 2,
  localparam int NB = ADDR_W / DATA_W,
  localparam int SW = (NUM_IDX > 1) ? $clog2(NUM_IDX) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hold,
  input  logic                      start,
  input  logic [2:0]                mode,
  input  logic [SW-1:0]             idx_sel,
  input  logic [NUM_IDX*ADDR_W-1:0] idx_in,
  input  logic [DATA_W-1:0]         acc_in,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      data_valid,
  output logic                      fetch_req,
  output logic                      busy,
  output logic [ADDR_W-1:0]         ea,
  output logic                      ea_valid,
  output logic                      page_cross
);
  typedef enum logic [1:0] {IDLE, FETCH, CALC} state_t;
  state_t state, state_n;
  logic [2:0] mode_r, cnt;
  logic [ADDR_W-1:0] idx_r, idx_pick, op_buf, res, base;
  logic [DATA_W-1:0] acc_r;
  logic signed [DATA_W-1:0] w0;
  logic last, pc_en, pc;
  assign fetch_req = state == FETCH;
  assign busy = state != IDLE;
  assign w0 = op_buf[DATA_W-1:0];
  assign last = mode_r != 3'd1 || cnt == 3'(NB - 1);
  assign idx_pick = (int'(idx_sel) < NUM_IDX) ? idx_in[int'(idx_sel)*ADDR_W +: ADDR_W] : '0;
  always_comb begin
    state_n = state == IDLE  ? (start ? (mode < 3'd4 ? FETCH : CALC) : IDLE) :
              state == FETCH ? (data_valid && last ? CALC : FETCH) : IDLE;
  end
  always_comb begin
    res = '0;
    base = idx_r;
    pc_en = 1'b0;
    case (mode_r)
      3'd0: res = ADDR_W'($unsigned(w0));
      3'd1: res = op_buf;
      3'd2: begin res = idx_r + ADDR_W'($unsigned(w0)); pc_en = 1'b1; end
      3'd3: begin res = idx_r + ADDR_W'(w0); pc_en = 1'b1; end
      3'd4: begin res = idx_r + ADDR_W'(acc_r); pc_en = 1'b1; end
      3'd5: begin res = ea + ADDR_W'(1); base = ea; pc_en = 1'b1; end
      3'd6: res = idx_r;
      default: res = '0;
    endcase
    pc = pc_en && ((res >> 8) != (base >> 8));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      mode_r <= '0;
      idx_r <= '0;
      acc_r <= '0;
      op_buf <= '0;
      ea <= '0;
      ea_valid <= 1'b0;
      page_cross <= 1'b0;
    end else if (!hold) begin
      state <= state_n;
      ea_valid <= state == CALC;
      if (state == IDLE && start) begin
        mode_r <= mode;
        idx_r <= idx_pick;
        acc_r <= acc_in;
        cnt <= '0;
        op_buf <= '0;
      end
      // operand words arrive most significant first, so shift left
      if (state == FETCH && data_valid) begin
        op_buf <= (op_buf << DATA_W) | ADDR_W'(data_in);
        cnt <= cnt + 3'd1;
      end
      if (state == CALC) begin
        ea <= res;
        page_cross <= pc;
      end
    end
  end
endmodule

// File: tb/tb_ea_gen_unit.sv
// tb_ea_gen_unit: directed scoreboard bench for ea_gen_unit
module tb_ea_gen_unit;
  logic clk = 1'b0, rst = 1'b1, hold = 1'b0, start = 1'b0, data_valid = 1'b0;
  logic [2:0] mode = '0;
  logic [0:0] idx_sel = '0;
  logic [31:0] idx_in = '0;
  logic [7:0] acc_in = '0, data_in = '0;
  logic fetch_req, busy, ea_valid, page_cross;
  logic [15:0] ea;
  logic [16:0] sb[$];
  int n_cmp = 0, n_err = 0, lat = 0, tot = 0;

  ea_gen_unit dut (
    .clk(clk), .rst(rst), .hold(hold), .start(start), .mode(mode), .idx_sel(idx_sel),
    .idx_in(idx_in), .acc_in(acc_in), .data_in(data_in), .data_valid(data_valid),
    .fetch_req(fetch_req), .busy(busy), .ea(ea), .ea_valid(ea_valid), .page_cross(page_cross)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [2:0] m, input logic s);
    mode = m;
    idx_sel = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] w);
    data_in = w;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  // waits a bounded number of cycles for ea_valid, then checks result and pulse width
  task automatic expect_valid(input string tag, output int n);
    logic [16:0] e;
    n = 0;
    while (!ea_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(ea_valid), 32'd1);
    if (ea_valid) begin
      chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
      e = (sb.size() > 0) ? sb.pop_front() : 17'h1ffff;
      chk({tag, "_ea"}, 32'(ea), 32'(e[15:0]));
      chk({tag, "_pc"}, 32'(page_cross), 32'(e[16]));
      chk({tag, "_busy_low"}, 32'(busy), 32'd0);
      tick();
      chk({tag, "_pulse_end"}, 32'(ea_valid), 32'd0);
    end
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ea", 32'(ea), 32'h0);
    chk("rst_valid", 32'(ea_valid), 32'd0);
    chk("rst_pc", 32'(page_cross), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fetch", 32'(fetch_req), 32'd0);
    // IDX_ACC with capture check: inputs change after start
    idx_in = {16'h0005, 16'h12F0};
    acc_in = 8'h20;
    sb.push_back({1'b1, 16'h1310});
    do_start(3'd4, 1'b0);
    idx_in[15:0] = 16'h0000;
    acc_in = 8'hFF;
    chk("idxacc_busy", 32'(busy), 32'd1);
    chk("idxacc_early", 32'(ea_valid), 32'd0);
    expect_valid("idxacc", lat);
    chk("idxacc_lat", 32'(lat), 32'd1);
    idx_in[15:0] = 16'h12F0;
    // EXT with 3-cycle gap
    sb.push_back({1'b0, 16'hABCD});
    do_start(3'd1, 1'b0);
    chk("ext_fetch_req", 32'(fetch_req), 32'd1);
    feed(8'hAB);
    for (int i = 0; i < 3; i++) begin
      chk("ext_gap_fetch", 32'(fetch_req), 32'd1);
      tick();
    end
    feed(8'hCD);
    chk("ext_fetch_drop", 32'(fetch_req), 32'd0);
    chk("ext_not_yet", 32'(ea_valid), 32'd0);
    expect_valid("ext", lat);
    chk("ext_lat", 32'(lat), 32'd1);
    // IDX_S via Y
    sb.push_back({1'b0, 16'h0000});
    do_start(3'd3, 1'b1);
    feed(8'hFB);
    expect_valid("idxs_a", lat);
    idx_in[31:16] = 16'h0003;
    sb.push_back({1'b1, 16'hFFFE});
    do_start(3'd3, 1'b1);
    feed(8'hFB);
    expect_valid("idxs_b", lat);
    // DIR 0xFF then INC then CLR
    sb.push_back({1'b0, 16'h00FF});
    do_start(3'd0, 1'b0);
    feed(8'hFF);
    expect_valid("dir", lat);
    sb.push_back({1'b1, 16'h0100});
    do_start(3'd5, 1'b0);
    expect_valid("inc", lat);
    sb.push_back({1'b0, 16'h0000});
    do_start(3'd7, 1'b0);
    expect_valid("clr", lat);
    // IDX_U with unsigned offset
    sb.push_back({1'b0, 16'h12FF});
    do_start(3'd2, 1'b0);
    feed(8'h0F);
    expect_valid("idxu", lat);
    // hold 4 cycles during DIR fetch
    sb.push_back({1'b0, 16'h005A});
    do_start(3'd0, 1'b0);
    tot = 1;
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 8'h11 + 8'(i);
      data_valid = i[0];
      tick();
      tot++;
      chk("hold_fetch_req", 32'(fetch_req), 32'd1);
      chk("hold_no_valid", 32'(ea_valid), 32'd0);
    end
    hold = 1'b0;
    feed(8'h5A);
    tot++;
    expect_valid("hold_dir", lat);
    chk("hold_total", 32'(tot + lat), 32'd7);
    // hold during CALC of IDX
    sb.push_back({1'b0, 16'h12F0});
    do_start(3'd6, 1'b0);
    hold = 1'b1;
    tick();
    tick();
    chk("hold_calc_busy", 32'(busy), 32'd1);
    chk("hold_calc_valid", 32'(ea_valid), 32'd0);
    hold = 1'b0;
    expect_valid("hold_idx", lat);
    chk("hold_idx_lat", 32'(lat), 32'd1);
    // reset mid-EXT
    do_start(3'd1, 1'b0);
    feed(8'hAB);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_ea", 32'(ea), 32'h0);
    chk("rst2_pc", 32'(page_cross), 32'd0);
    chk("rst2_busy", 32'(busy), 32'd0);
    chk("rst2_fetch", 32'(fetch_req), 32'd0);
    feed(8'hCD);
    for (int i = 0; i < 4; i++) begin
      chk("rst2_no_valid", 32'(ea_valid), 32'd0);
      tick();
    end
    // start while busy is ignored
    sb.push_back({1'b0, 16'h1234});
    do_start(3'd1, 1'b0);
    feed(8'h12);
    do_start(3'd7, 1'b0);
    feed(8'h34);
    expect_valid("busy_start", lat);
    for (int i = 0; i < 3; i++) begin
      chk("busy_start_no_extra", 32'(ea_valid), 32'd0);
      tick();
    end
    chk("busy_start_ea_kept", 32'(ea), 32'h1234);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
